csr_commit_ctrl: RTL and testbench
==================================

Name: csr_commit_ctrl

Overview:
- Commit-side sequencer that drains the single-entry CSR address buffer.
- When the instruction at the commit head is a CSR op, it performs a read-modify-write on the CSR register file over a req/gnt/rvalid handshake and returns the old CSR value for write-back to rd.
- It then pulses csr_commit_o back to the buffer to release it.
- Sits between the CSR address buffer and the CSR file, driven by the commit stage.

Parameters:
- TIMEOUT_CYCLES, 16, max cycles waited for csr_rvalid_i after a grant before raising a timeout exception (>=2).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- flush_i  in  1  pipeline flush
- commit_valid_i  in  1  commit head is a CSR instruction
- commit_op_i  in  2  00 CSRRW, 01 CSRRS, 10 CSRRC, 11 read-only
- commit_wdata_i  in  64  operand (rs1 value/imm) from the buffer result
- csr_addr_i  in  12  buffered CSR address
- commit_ack_o  out  1  one-cycle: CSR instruction retired
- csr_commit_o  out  1  one-cycle: release the address buffer
- wb_valid_o  out  1  one-cycle: wb_data_o valid for rd
- wb_data_o  out  64  old CSR value
- exception_o  out  1  one-cycle: illegal access or timeout
- exception_cause_o  out  2  01 illegal, 10 timeout, 00 none
- csr_req_o  out  1  request to CSR file
- csr_we_o  out  1  1 = write, 0 = read
- csr_addr_o  out  12  CSR address
- csr_wdata_o  out  64  write data
- csr_gnt_i  in  1  request accepted
- csr_rvalid_i  in  1  response (read data / write ack)
- csr_rdata_i  in  64  read data
- csr_ex_i  in  1  access illegal; qualified by csr_rvalid_i

Behaviour:
- Reset (rst_i=1 at posedge): state IDLE, timer 0, latched addr/op/wdata/rdata 0. All outputs 0.
- Registered state: IDLE, RD, RWAIT, WR, WACK, DONE.
- IDLE:
  - commit_valid_i=1 and flush_i=0: latch csr_addr_i, commit_op_i, commit_wdata_i; go to RD.
  - commit_valid_i is ignored in every other state.
- RD: csr_req_o=1, csr_we_o=0, csr_addr_o=latched addr. Stays in RD until csr_gnt_i=1, then RWAIT with timer cleared.
- RWAIT: timer increments each cycle.
  - csr_rvalid_i=1: latch csr_rdata_i.
    - If csr_ex_i=1 or op=11: go to DONE (no write).
    - Otherwise go to WR.
  - Timer reaches TIMEOUT_CYCLES-1 without rvalid: go to DONE with cause timeout.
- Write data:
  - CSRRW: wdata.
  - CSRRS: old | wdata.
  - CSRRC: old & ~wdata.
  - Full 64-bit, registered on entry to WR.
- WR: csr_req_o=1, csr_we_o=1, csr_wdata_o=computed value. On csr_gnt_i go to WACK, timer cleared.
- WACK: waits for csr_rvalid_i (csr_ex_i=1 here gives cause illegal), or times out as in RWAIT. Then DONE.
- DONE (exactly one cycle, then IDLE):
  - csr_commit_o=1 and commit_ack_o=1 always.
  - No exception: wb_valid_o=1, wb_data_o=old value.
  - Exception: exception_o=1, exception_cause_o set, wb_valid_o=0.
- Minimum latency with gnt same cycle and rvalid next cycle:
  - Read-only: commit_valid_i at cycle 0, DONE at cycle 3.
  - RMW: DONE at cycle 5.
- csr_req_o is held with stable addr/we/wdata until granted; it never drops without a grant.
- Flush:
  - In RD or RWAIT: return to IDLE next cycle; no write, no DONE pulses. A late csr_rvalid_i is dropped.
  - In WR, WACK or DONE: ignored; the write completes and DONE fires. Write is the commit point.
- Simultaneous csr_gnt_i and csr_rvalid_i in RD is not allowed; rvalid is at least one cycle after gnt.
- csr_rvalid_i in IDLE, RD or WR is ignored.
- Reset mid-operation: immediate return to IDLE and outputs 0 on the next edge, even with csr_req_o pending.

Test Plan:
- CSRRS, addr 0x300, wdata 0x8, CSR file returns 0x1800, gnt immediate, rvalid +1:
  - Read req, then write req with 0x1808.
  - DONE at cycle 5: wb_data_o=0x1800, csr_commit_o=1 for one cycle.
- CSRRC, wdata 0xF, old 0xFF -> write 0xF0.
- Read-only op, old 0x1234 -> no write request; DONE at cycle 3, wb_data_o=0x1234.
- csr_gnt_i held low 4 cycles in RD -> csr_req_o, csr_addr_o, csr_we_o stable all 4 cycles; sequence completes normally afterwards.
- rvalid with csr_ex_i=1 on read -> no write, exception_o=1, cause 01, wb_valid_o=0, csr_commit_o=1.
- No rvalid for 16 cycles after gnt -> exception cause 10 on the cycle after timeout.
- Flush in RWAIT -> IDLE, no commit pulse; late rvalid ignored.
- Flush in WACK -> DONE still fires.
- Reset asserted in WR -> all outputs 0 next cycle, state IDLE.

Source files
------------

// File: rtl/csr_commit_ctrl.sv
// csr_commit_ctrl: commit-side sequencer that drains the single-entry CSR
// address buffer. It runs a read-modify-write on the CSR file when a CSR op
// reaches the commit head, returns the old value for rd, and pulses
// csr_commit_o to release the buffer.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   flush_i               pipeline flush (honoured before the write phase only)
//   commit_valid_i/op/wdata/csr_addr_i   CSR instruction at commit head
//   commit_ack_o, csr_commit_o           one-cycle retire / buffer release
//   wb_valid_o, wb_data_o                old CSR value for rd
//   exception_o, exception_cause_o       01 illegal, 10 timeout
//   csr_req_o/we/addr/wdata, csr_gnt_i   request channel to the CSR file
//   csr_rvalid_i/rdata/ex_i              response channel from the CSR file
module csr_commit_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        commit_valid_i,
  input  logic [1:0]  commit_op_i,
  input  logic [63:0] commit_wdata_i,
  input  logic [11:0] csr_addr_i,
  output logic        commit_ack_o,
  output logic        csr_commit_o,
  output logic        wb_valid_o,
  output logic [63:0] wb_data_o,
  output logic        exception_o,
  output logic [1:0]  exception_cause_o,
  output logic        csr_req_o,
  output logic        csr_we_o,
  output logic [11:0] csr_addr_o,
  output logic [63:0] csr_wdata_o,
  input  logic        csr_gnt_i,
  input  logic        csr_rvalid_i,
  input  logic [63:0] csr_rdata_i,
  input  logic        csr_ex_i
);

  localparam int unsigned XLEN    = 64;
  localparam int unsigned ADDR_W  = 12;
  localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES);

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] OP_RW = 2'b00;
  localparam logic [1:0] OP_RS = 2'b01;
  localparam logic [1:0] OP_RC = 2'b10;
  localparam logic [1:0] OP_RO = 2'b11;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    RWAIT = 3'd2,
    WR    = 3'd3,
    WACK  = 3'd4,
    DONE  = 3'd5
  } state_e;

  // Sequencer state and per-instruction context
  state_e              state_q,  state_d;
  logic [TIMER_W-1:0]  timer_q,  timer_d;
  logic [ADDR_W-1:0]   addr_q,   addr_d;
  logic [1:0]          op_q,     op_d;
  logic [XLEN-1:0]     operand_q, operand_d;
  logic [XLEN-1:0]     old_q,    old_d;
  logic [XLEN-1:0]     wr_val_q, wr_val_d;
  logic [1:0]          cause_q,  cause_d;

  // Registered outputs
  logic                commit_ack_q,   commit_ack_d;
  logic                csr_commit_q,   csr_commit_d;
  logic                wb_valid_q,     wb_valid_d;
  logic [XLEN-1:0]     wb_data_q,      wb_data_d;
  logic                exception_q,    exception_d;
  logic [1:0]          exc_cause_q,    exc_cause_d;
  logic                csr_req_q,      csr_req_d;
  logic                csr_we_q,       csr_we_d;
  logic [ADDR_W-1:0]   csr_addr_q,     csr_addr_d;
  logic [XLEN-1:0]     csr_wdata_q,    csr_wdata_d;

  // New CSR value from the old value and the instruction operand
  function automatic logic [XLEN-1:0] rmw_value(input logic [1:0]      op,
                                                input logic [XLEN-1:0] old_val,
                                                input logic [XLEN-1:0] operand);
    logic [XLEN-1:0] res;
    case (op)
      OP_RS:   res = old_val | operand;
      OP_RC:   res = old_val & ~operand;
      default: res = operand;
    endcase
    return res;
  endfunction

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    addr_d    = addr_q;
    op_d      = op_q;
    operand_d = operand_q;
    old_d     = old_q;
    wr_val_d  = wr_val_q;
    cause_d   = cause_q;

    case (state_q)
      IDLE: begin
        if (commit_valid_i && !flush_i) begin
          addr_d    = csr_addr_i;
          op_d      = commit_op_i;
          operand_d = commit_wdata_i;
          cause_d   = CAUSE_NONE;
          state_d   = RD;
        end
      end

      RD: begin
        if (flush_i) begin
          state_d = IDLE;
        end else if (csr_gnt_i) begin
          timer_d = '0;
          state_d = RWAIT;
        end
      end

      // Response wins over timeout when both land on the last timer cycle
      RWAIT: begin
        if (flush_i) begin
          state_d = IDLE;
        end else if (csr_rvalid_i) begin
          old_d = csr_rdata_i;
          if (csr_ex_i) begin
            cause_d = CAUSE_ILLEGAL;
            state_d = DONE;
          end else if (op_q == OP_RO) begin
            state_d = DONE;
          end else begin
            wr_val_d = rmw_value(op_q, csr_rdata_i, operand_q);
            state_d  = WR;
          end
        end else if (timer_q == TIMER_LAST) begin
          cause_d = CAUSE_TIMEOUT;
          state_d = DONE;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end

      // Write phase is past the commit point: flush no longer applies
      WR: begin
        if (csr_gnt_i) begin
          timer_d = '0;
          state_d = WACK;
        end
      end

      WACK: begin
        if (csr_rvalid_i) begin
          if (csr_ex_i) begin
            cause_d = CAUSE_ILLEGAL;
          end
          state_d = DONE;
        end else if (timer_q == TIMER_LAST) begin
          cause_d = CAUSE_TIMEOUT;
          state_d = DONE;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they line up with it
    csr_req_d    = (state_d == RD) || (state_d == WR);
    csr_we_d     = (state_d == WR);
    csr_addr_d   = csr_req_d ? addr_d : '0;
    csr_wdata_d  = (state_d == WR) ? wr_val_d : '0;

    csr_commit_d = (state_d == DONE);
    commit_ack_d = (state_d == DONE);
    exception_d  = (state_d == DONE) && (cause_d != CAUSE_NONE);
    exc_cause_d  = (state_d == DONE) ? cause_d : CAUSE_NONE;
    wb_valid_d   = (state_d == DONE) && (cause_d == CAUSE_NONE);
    wb_data_d    = wb_valid_d ? old_d : '0;
  end

  // State and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      addr_q       <= '0;
      op_q         <= '0;
      operand_q    <= '0;
      old_q        <= '0;
      wr_val_q     <= '0;
      cause_q      <= CAUSE_NONE;
      commit_ack_q <= 1'b0;
      csr_commit_q <= 1'b0;
      wb_valid_q   <= 1'b0;
      wb_data_q    <= '0;
      exception_q  <= 1'b0;
      exc_cause_q  <= CAUSE_NONE;
      csr_req_q    <= 1'b0;
      csr_we_q     <= 1'b0;
      csr_addr_q   <= '0;
      csr_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      addr_q       <= addr_d;
      op_q         <= op_d;
      operand_q    <= operand_d;
      old_q        <= old_d;
      wr_val_q     <= wr_val_d;
      cause_q      <= cause_d;
      commit_ack_q <= commit_ack_d;
      csr_commit_q <= csr_commit_d;
      wb_valid_q   <= wb_valid_d;
      wb_data_q    <= wb_data_d;
      exception_q  <= exception_d;
      exc_cause_q  <= exc_cause_d;
      csr_req_q    <= csr_req_d;
      csr_we_q     <= csr_we_d;
      csr_addr_q   <= csr_addr_d;
      csr_wdata_q  <= csr_wdata_d;
    end
  end

  assign commit_ack_o      = commit_ack_q;
  assign csr_commit_o      = csr_commit_q;
  assign wb_valid_o        = wb_valid_q;
  assign wb_data_o         = wb_data_q;
  assign exception_o       = exception_q;
  assign exception_cause_o = exc_cause_q;
  assign csr_req_o         = csr_req_q;
  assign csr_we_o          = csr_we_q;
  assign csr_addr_o        = csr_addr_q;
  assign csr_wdata_o       = csr_wdata_q;

endmodule

// File: tb/tb_csr_commit_ctrl.sv
// Scoreboard bench for csr_commit_ctrl: a scripted CSR-file responder drives
// randomized transactions and pushes the expected requests and retire results;
// an independent monitor pops and compares them as the DUT presents them.
module tb_csr_commit_ctrl;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        flush_i = 1'b0;
  logic        commit_valid_i = 1'b0;
  logic [1:0]  commit_op_i = 2'b00;
  logic [63:0] commit_wdata_i = 64'h0;
  logic [11:0] csr_addr_i = 12'h0;
  logic        commit_ack_o;
  logic        csr_commit_o;
  logic        wb_valid_o;
  logic [63:0] wb_data_o;
  logic        exception_o;
  logic [1:0]  exception_cause_o;
  logic        csr_req_o;
  logic        csr_we_o;
  logic [11:0] csr_addr_o;
  logic [63:0] csr_wdata_o;
  logic        csr_gnt_i = 1'b0;
  logic        csr_rvalid_i = 1'b0;
  logic [63:0] csr_rdata_i = 64'h0;
  logic        csr_ex_i = 1'b0;

  always #5 clk = ~clk;

  csr_commit_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .flush_i           (flush_i),
    .commit_valid_i    (commit_valid_i),
    .commit_op_i       (commit_op_i),
    .commit_wdata_i    (commit_wdata_i),
    .csr_addr_i        (csr_addr_i),
    .commit_ack_o      (commit_ack_o),
    .csr_commit_o      (csr_commit_o),
    .wb_valid_o        (wb_valid_o),
    .wb_data_o         (wb_data_o),
    .exception_o       (exception_o),
    .exception_cause_o (exception_cause_o),
    .csr_req_o         (csr_req_o),
    .csr_we_o          (csr_we_o),
    .csr_addr_o        (csr_addr_o),
    .csr_wdata_o       (csr_wdata_o),
    .csr_gnt_i         (csr_gnt_i),
    .csr_rvalid_i      (csr_rvalid_i),
    .csr_rdata_i       (csr_rdata_i),
    .csr_ex_i          (csr_ex_i)
  );

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [63:0] wdata;
  } req_t;

  typedef struct {
    logic [1:0]  cause;
    logic [63:0] data;
    int unsigned cyc;
  } done_t;

  req_t  req_q[$];
  done_t done_q[$];

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Values as sampled by the DUT at the last edge
  logic        p_req = 1'b0, p_gnt = 1'b0, p_flush = 1'b0, p_rst = 1'b0;
  logic        p_we = 1'b0, p_commit = 1'b0;
  logic [11:0] p_addr = 12'h0;
  logic [63:0] p_wdata = 64'h0;

  always @(posedge clk) begin
    p_req    <= csr_req_o;
    p_gnt    <= csr_gnt_i;
    p_flush  <= flush_i;
    p_rst    <= rst_i;
    p_we     <= csr_we_o;
    p_addr   <= csr_addr_o;
    p_wdata  <= csr_wdata_o;
    p_commit <= csr_commit_o;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a request or a retire
  always @(negedge clk) begin
    if (p_rst) begin
      chk("reset_outputs_zero",
          64'(csr_req_o | csr_we_o | (|csr_addr_o) | (|csr_wdata_o) | commit_ack_o |
              csr_commit_o | wb_valid_o | (|wb_data_o) | exception_o | (|exception_cause_o)),
          64'h0);
    end else begin
      if (p_req && !p_gnt && !(p_flush && !p_we)) begin
        chk("req_held", 64'(csr_req_o), 64'h1);
        chk("req_addr_stable", 64'(csr_addr_o), 64'(p_addr));
        chk("req_we_stable", 64'(csr_we_o), 64'(p_we));
        if (p_we) chk("req_wdata_stable", csr_wdata_o, p_wdata);
      end
      if (csr_req_o && csr_gnt_i) begin
        if (req_q.size() == 0) begin
          chk("unexpected_req", 64'(csr_req_o), 64'h0);
        end else begin
          req_t r;
          r = req_q.pop_front();
          chk("req_we", 64'(csr_we_o), 64'(r.we));
          chk("req_addr", 64'(csr_addr_o), 64'(r.addr));
          if (r.we) chk("req_wdata", csr_wdata_o, r.wdata);
        end
      end
      if (csr_commit_o) begin
        chk("commit_ack", 64'(commit_ack_o), 64'h1);
        chk("commit_single_cycle", 64'(p_commit), 64'h0);
        if (done_q.size() == 0) begin
          chk("unexpected_commit", 64'(csr_commit_o), 64'h0);
        end else begin
          done_t d;
          d = done_q.pop_front();
          chk("done_cycle", 64'(cyc), 64'(d.cyc));
          chk("exception", 64'(exception_o), 64'(d.cause != 2'b00));
          chk("exception_cause", 64'(exception_cause_o), 64'(d.cause));
          chk("wb_valid", 64'(wb_valid_o), 64'(d.cause == 2'b00));
          if (d.cause == 2'b00) chk("wb_data", wb_data_o, d.data);
        end
      end else begin
        chk("no_stray_retire", 64'({commit_ack_o, wb_valid_o, exception_o}), 64'h0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // commit_* inputs carry junk while busy; the DUT must ignore them
  task automatic busy_noise();
    commit_valid_i = 1'($urandom);
    commit_op_i    = 2'($urandom);
    commit_wdata_i = {$urandom, $urandom};
    csr_addr_i     = 12'($urandom);
  endtask

  // DUT back in IDLE: a late response must be dropped
  task automatic idle_late();
    commit_valid_i = 1'b0;
    flush_i        = 1'b0;
    csr_gnt_i      = 1'b0;
    csr_rvalid_i   = 1'b1;
    csr_rdata_i    = {$urandom, $urandom};
    csr_ex_i       = 1'($urandom);
    step();
    csr_rvalid_i   = 1'b0;
    csr_ex_i       = 1'b0;
  endtask

  function automatic int lim(input int x);
    return (x < T) ? x : T - 1;
  endfunction

  // fmode: 0 none, 1 flush in RD, 2 in RWAIT, 3 in WR, 4 in WACK, 5 in DONE
  task automatic run_txn(input logic [1:0] op, input logic [11:0] addr,
                         input logic [63:0] wd, input logic [63:0] old,
                         input int gd1, input int rd1, input logic ex1,
                         input int gd2, input int rd2, input logic ex2,
                         input int fmode, input int fidx);
    logic        wr_exp;
    logic [63:0] nv;
    logic [1:0]  cause;
    int          lat;
    int unsigned n;
    wr_exp = (rd1 < T) && !ex1 && (op != 2'b11);
    case (op)
      2'b00:   nv = wd;
      2'b01:   nv = old | wd;
      2'b10:   nv = old & ~wd;
      default: nv = 64'h0;
    endcase
    n = cyc;
    if (fmode != 1) req_q.push_back(req_t'{1'b0, addr, 64'h0});
    if (fmode != 1 && fmode != 2) begin
      if (wr_exp) req_q.push_back(req_t'{1'b1, addr, nv});
      if (rd1 >= T)              cause = 2'b10;
      else if (ex1)              cause = 2'b01;
      else if (wr_exp && rd2 >= T) cause = 2'b10;
      else if (wr_exp && ex2)    cause = 2'b01;
      else                       cause = 2'b00;
      lat = 3 + gd1 + lim(rd1) + (wr_exp ? 2 + gd2 + lim(rd2) : 0);
      done_q.push_back(done_t'{cause, old, n + 32'(lat)});
    end

    commit_valid_i = 1'b1;
    commit_op_i    = op;
    commit_wdata_i = wd;
    csr_addr_i     = addr;
    flush_i        = 1'b0;
    csr_gnt_i      = 1'b0;
    csr_rvalid_i   = 1'b0;
    step();

    for (int j = 0; j <= gd1; j++) begin
      busy_noise();
      csr_rdata_i = {$urandom, $urandom};
      csr_ex_i    = 1'($urandom);
      if (fmode == 1 && j == fidx) begin
        flush_i      = 1'b1;
        csr_gnt_i    = 1'b0;
        csr_rvalid_i = 1'($urandom);
        step();
        idle_late();
        return;
      end
      csr_gnt_i    = (j == gd1);
      csr_rvalid_i = (j == gd1) ? 1'b0 : 1'($urandom);
      step();
    end
    csr_gnt_i = 1'b0;

    for (int k = 0; k < T; k++) begin
      busy_noise();
      csr_rvalid_i = (k == rd1);
      csr_rdata_i  = (k == rd1) ? old : {$urandom, $urandom};
      csr_ex_i     = (k == rd1) ? ex1 : 1'($urandom);
      if (fmode == 2 && k == fidx) begin
        flush_i = 1'b1;
        step();
        idle_late();
        return;
      end
      step();
      if (k == rd1) break;
    end
    csr_rvalid_i = 1'b0;
    csr_ex_i     = 1'b0;

    if (wr_exp) begin
      for (int j = 0; j <= gd2; j++) begin
        busy_noise();
        flush_i      = (fmode == 3 && j == fidx);
        csr_gnt_i    = (j == gd2);
        csr_rvalid_i = (j == gd2) ? 1'b0 : 1'($urandom);
        csr_rdata_i  = {$urandom, $urandom};
        csr_ex_i     = 1'($urandom);
        step();
      end
      csr_gnt_i = 1'b0;
      for (int k = 0; k < T; k++) begin
        busy_noise();
        flush_i      = (fmode == 4 && k == fidx);
        csr_rvalid_i = (k == rd2);
        csr_rdata_i  = {$urandom, $urandom};
        csr_ex_i     = (k == rd2) ? ex2 : 1'($urandom);
        step();
        if (k == rd2) break;
      end
      csr_rvalid_i = 1'b0;
      csr_ex_i     = 1'b0;
    end

    busy_noise();
    flush_i = (fmode == 5);
    step();
    flush_i        = 1'b0;
    commit_valid_i = 1'b0;
  endtask

  // Reach WR with a write pending, then reset before it is granted
  task automatic reset_in_wr();
    req_q.push_back(req_t'{1'b0, 12'h7C0, 64'h0});
    commit_valid_i = 1'b1;
    commit_op_i    = 2'b00;
    commit_wdata_i = 64'hDEAD_BEEF;
    csr_addr_i     = 12'h7C0;
    step();
    commit_valid_i = 1'b0;
    csr_gnt_i      = 1'b1;
    step();
    csr_gnt_i      = 1'b0;
    csr_rvalid_i   = 1'b1;
    csr_rdata_i    = 64'h55;
    csr_ex_i       = 1'b0;
    step();
    csr_rvalid_i   = 1'b0;
    chk("wr_pending_before_reset", 64'({csr_req_o, csr_we_o}), 64'h3);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    repeat (3) step();
    rst_i = 1'b0;
    step();

    // Directed cases
    run_txn(2'b01, 12'h300, 64'h8,  64'h1800, 0, 0, 1'b0, 0, 0, 1'b0, 0, 0);
    run_txn(2'b10, 12'h301, 64'hF,  64'hFF,   0, 0, 1'b0, 0, 0, 1'b0, 0, 0);
    run_txn(2'b11, 12'h342, 64'h77, 64'h1234, 0, 0, 1'b0, 0, 0, 1'b0, 0, 0);
    run_txn(2'b00, 12'h305, 64'hA5, 64'h9,    4, 1, 1'b0, 2, 0, 1'b0, 0, 0);
    run_txn(2'b01, 12'hF11, 64'h1,  64'h42,   0, 0, 1'b1, 0, 0, 1'b0, 0, 0);
    run_txn(2'b00, 12'h340, 64'h3,  64'h4,    0, T, 1'b0, 0, 0, 1'b0, 0, 0);
    run_txn(2'b01, 12'h341, 64'h3,  64'h4,    0, 3, 1'b0, 0, 0, 1'b0, 2, 1);
    run_txn(2'b00, 12'h343, 64'h6,  64'h4,    0, 0, 1'b0, 1, 2, 1'b0, 4, 0);
    run_txn(2'b10, 12'h344, 64'h6,  64'h7,    1, 0, 1'b0, 0, 1, 1'b1, 0, 0);
    run_txn(2'b01, 12'h345, 64'h6,  64'h7,    0, 2, 1'b0, 0, T, 1'b0, 0, 0);
    run_txn(2'b00, 12'h346, 64'h6,  64'h7,    3, 0, 1'b0, 0, 0, 1'b0, 1, 2);
    reset_in_wr();

    // Flush in IDLE blocks the start of an instruction
    commit_valid_i = 1'b1;
    flush_i        = 1'b1;
    step();
    commit_valid_i = 1'b0;
    flush_i        = 1'b0;
    chk("flush_idle_no_req", 64'(csr_req_o), 64'h0);
    step();
    chk("flush_idle_still_idle", 64'(csr_req_o), 64'h0);

    // Randomized traffic
    for (int t = 0; t < 300; t++) begin
      int gd1, rd1, gd2, rd2, fmode, fidx;
      logic ex1, ex2;
      gd1   = $urandom_range(0, 5);
      rd1   = ($urandom_range(0, 7) == 0) ? T : $urandom_range(0, ($urandom_range(0, 3) == 0) ? T - 1 : 4);
      ex1   = ($urandom_range(0, 7) == 0);
      gd2   = $urandom_range(0, 5);
      rd2   = ($urandom_range(0, 7) == 0) ? T : $urandom_range(0, 4);
      ex2   = ($urandom_range(0, 7) == 0);
      fmode = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5) : 0;
      fidx  = 0;
      case (fmode)
        1: begin
          if (gd1 == 0) gd1 = 1;
          fidx = $urandom_range(0, gd1 - 1);
        end
        2: fidx = $urandom_range(0, lim(rd1));
        3: fidx = $urandom_range(0, gd2);
        4: fidx = $urandom_range(0, lim(rd2));
        default: fidx = 0;
      endcase
      run_txn(2'($urandom), 12'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
              gd1, rd1, ex1, gd2, rd2, ex2, fmode, fidx);
    end

    step();
    step();
    chk("req_queue_drained", 64'(req_q.size()), 64'h0);
    chk("done_queue_drained", 64'(done_q.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
